// File: rtl/cia_sp_peer_if.sv
// Host-side handshake bundle of the CIA serial-port peer: the transmit
// request channel and the receive result channel.
interface cia_sp_peer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err
  );
endinterface

// File: rtl/cia_sp_peer.sv
// CIA serial-port peer. The transmit side plays the external device that
// drives the CIA's SP/CNT inputs: each byte goes out MSB first with CNT
// low for CNT_DIV phi2 ticks and then high for CNT_DIV phi2 ticks. The
// byte is followed by a gap during which the CIA moves its shift register
// into SDR. The receive side shifts in the CIA's SP output on CNT rising
// edges and drops a partial byte once CNT has been quiet for RX_TIMEOUT
// ticks. Transmit and receive are mutually exclusive: a new byte is sent
// only when no receive byte is in progress.
module cia_sp_peer #(
  parameter int CNT_DIV    = 4,
  parameter int RX_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         phi2_p,
  cia_sp_peer_if.slave host,
  output logic         sp_out,
  output logic         cnt_out,
  input  logic         sp_in,
  input  logic         cnt_in,
  output logic         busy
);

  localparam int TW   = $clog2(2 * CNT_DIV + 1);
  localparam int TO_W = $clog2(RX_TIMEOUT + 1);

  localparam logic [TW-1:0]   HALF_LAST = TW'(CNT_DIV - 1);
  localparam logic [TW-1:0]   GAP_LAST  = TW'(2 * CNT_DIV - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(RX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

  tx_state_t       state_q;
  logic [TW-1:0]   tick_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      tx_byte_q;
  logic            tx_ready_q;
  logic            cnt_out_q;
  logic            sp_out_q;

  logic            cnt_in_prev_q;
  logic [7:0]      rx_sr_q;
  logic [2:0]      rx_cnt_q;
  logic [TO_W-1:0] to_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            rx_err_q;

  logic            accept;
  logic            rise;
  logic [2:0]      bit_idx_d;
  logic [7:0]      rx_shift_d;

  // A byte is taken only while idle and no receive byte is partially assembled.
  assign accept     = phi2_p && (state_q == IDLE) && host.tx_valid &&
                      tx_ready_q && (rx_cnt_q == 3'd0);
  // Receive edges are ignored while we are driving CNT ourselves.
  assign rise       = phi2_p && cnt_in && !cnt_in_prev_q && (state_q == IDLE);
  assign bit_idx_d  = bit_idx_q - 3'd1;
  assign rx_shift_d = {rx_sr_q[6:0], sp_in};

  // Transmit FSM: sequences LOW/HIGH half-periods per bit, then the SDR gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_idx_q  <= 3'd0;
      tx_ready_q <= 1'b1;
      cnt_out_q  <= 1'b1;
      sp_out_q   <= 1'b1;
    end else if (phi2_p) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= LOW;
            tick_q     <= '0;
            bit_idx_q  <= 3'd7;
            tx_ready_q <= 1'b0;
            cnt_out_q  <= 1'b0;
            sp_out_q   <= host.tx_data[7];
          end
        end
        LOW: begin
          if (tick_q == HALF_LAST) begin
            state_q   <= HIGH;
            tick_q    <= '0;
            cnt_out_q <= 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        HIGH: begin
          if (tick_q == HALF_LAST) begin
            tick_q <= '0;
            if (bit_idx_q != 3'd0) begin
              state_q   <= LOW;
              bit_idx_q <= bit_idx_d;
              cnt_out_q <= 1'b0;
              sp_out_q  <= tx_byte_q[bit_idx_d];
            end else begin
              state_q  <= GAP;
              sp_out_q <= 1'b1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        GAP: begin
          if (tick_q == GAP_LAST) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            tx_ready_q <= 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          tick_q     <= '0;
          tx_ready_q <= 1'b1;
          cnt_out_q  <= 1'b1;
          sp_out_q   <= 1'b1;
        end
      endcase
    end
  end

  // Transmit byte holder: captured once at acceptance, never re-sampled mid-byte.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_byte_q <= host.tx_data;
    end
  end

  // Receive shifter with edge detect, byte completion and quiet-line timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_in_prev_q <= 1'b1;
      rx_sr_q       <= 8'h00;
      rx_cnt_q      <= 3'd0;
      to_q          <= '0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (phi2_p) begin
        cnt_in_prev_q <= cnt_in;
        if (rise) begin
          rx_sr_q  <= rx_shift_d;
          rx_cnt_q <= rx_cnt_q + 3'd1;
          to_q     <= '0;
          if (rx_cnt_q == 3'd7) begin
            rx_data_q  <= rx_shift_d;
            rx_valid_q <= 1'b1;
          end
        end else if (rx_cnt_q != 3'd0) begin
          if (to_q == TO_LAST) begin
            rx_cnt_q <= 3'd0;
            rx_sr_q  <= 8'h00;
            to_q     <= '0;
            rx_err_q <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
      end
    end
  end

  assign host.tx_ready = tx_ready_q;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;
  assign host.rx_err   = rx_err_q;
  assign sp_out        = sp_out_q;
  assign cnt_out       = cnt_out_q;
  assign busy          = (state_q != IDLE) || (rx_cnt_q != 3'd0);

endmodule

// File: tb/tb_cia_sp_peer.sv
// Directed bench for cia_sp_peer with CNT_DIV=2, RX_TIMEOUT=16 and phi2
// active on every 4th clock.
module tb_cia_sp_peer;
  localparam int D  = 2;
  localparam int TO = 16;

  logic clk;
  logic reset;
  logic phi2_p;
  logic sp_out, cnt_out, sp_in, cnt_in, busy;
  int   checks = 0;
  int   errors = 0;

  cia_sp_peer_if hif ();

  cia_sp_peer #(.CNT_DIV(D), .RX_TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .phi2_p (phi2_p),
    .host   (hif),
    .sp_out (sp_out),
    .cnt_out(cnt_out),
    .sp_in  (sp_in),
    .cnt_in (cnt_in),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div    = 0;
    phi2_p = 1'b0;
    forever begin
      @(negedge clk);
      phi2_p = (div == 3);
      div    = (div + 1) % 4;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next clock edge on which phi2_p is high.
  task automatic tick();
    @(posedge clk);
    while (phi2_p !== 1'b1) @(posedge clk);
    #1;
  endtask

  // Check a transmitted byte tick by tick from acceptance (t=0) to idle.
  task automatic tx_run(input logic [7:0] b);
    logic ec, es, er;
    for (int t = 0; t <= 18 * D; t++) begin
      if (t > 0) tick();
      if (t < 16 * D) begin
        ec = ((t / D) % 2) == 1;
        es = b[7 - t / (2 * D)];
        er = 1'b0;
      end else if (t < 18 * D) begin
        ec = 1'b1; es = 1'b1; er = 1'b0;
      end else begin
        ec = 1'b1; es = 1'b1; er = 1'b1;
      end
      checks++;
      if ({cnt_out, sp_out, hif.tx_ready, busy} !== {ec, es, er, ~er}) begin
        errors++;
        $display("FAIL tx_%02h t=%0d cnt/sp/ready/busy got %b%b%b%b want %b%b%b%b",
                 b, t, cnt_out, sp_out, hif.tx_ready, busy, ec, es, er, ~er);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic nv, input logic [7:0] nd);
    hif.tx_data  = b;
    hif.tx_valid = 1'b1;
    tick();
    hif.tx_valid = nv;
    hif.tx_data  = nd;
    tx_run(b);
  endtask

  // One CNT rising edge carrying bit b; returns just after the edge tick.
  task automatic rx_edge(input logic b);
    sp_in  = b;
    cnt_in = 1'b0;
    tick();
    cnt_in = 1'b1;
    tick();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      rx_edge(b[i]);
      checks++;
      if (i > 0) begin
        if ({hif.rx_valid, busy} !== 2'b01) begin
          errors++;
          $display("FAIL rx_%02h bit%0d valid/busy got %b%b want 01", b, i, hif.rx_valid, busy);
        end
      end else if ({hif.rx_valid, hif.rx_data} !== {1'b1, b}) begin
        errors++;
        $display("FAIL rx_%02h done valid/data got %b/%02h want 1/%02h", b, hif.rx_valid, hif.rx_data, b);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({hif.rx_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rx_%02h after valid/busy got %b%b want 00", b, hif.rx_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    hif.tx_valid = 1'b0;
    hif.tx_data  = 8'h00;
    sp_in        = 1'b1;
    cnt_in       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hif.tx_ready, cnt_out, sp_out, hif.rx_data, hif.rx_valid, hif.rx_err, busy} !==
        {1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset ready/cnt/sp/rxd/rxv/err/busy got %b%b%b %02h %b%b%b want 111 00 000",
               hif.tx_ready, cnt_out, sp_out, hif.rx_data, hif.rx_valid, hif.rx_err, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({hif.tx_ready, cnt_out, sp_out, busy} !== 4'b1110) begin
      errors++;
      $display("FAIL idle ready/cnt/sp/busy got %b%b%b%b want 1110", hif.tx_ready, cnt_out, sp_out, busy);
    end
  endtask

  task automatic test_tx_a5();
    send(8'hA5, 1'b0, 8'h00);
  endtask

  task automatic test_rx_3c();
    rx_byte(8'h3C);
  endtask

  task automatic test_timeout();
    rx_edge(1'b1);
    rx_edge(1'b0);
    rx_edge(1'b1);
    for (int k = 1; k <= TO; k++) begin
      tick();
      checks++;
      if ({hif.rx_err, busy} !== {(k == TO), (k != TO)}) begin
        errors++;
        $display("FAIL timeout k=%0d err/busy got %b%b want %b%b", k, hif.rx_err, busy, (k == TO), (k != TO));
      end
    end
    checks++;
    if (hif.rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL timeout rx_data got %02h want 3c", hif.rx_data);
    end
    @(posedge clk); #1;
    checks++;
    if (hif.rx_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout err pulse width got %b want 0", hif.rx_err);
    end
    rx_byte(8'hFF);
  endtask

  task automatic test_pending();
    logic [7:0] b;
    b = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      rx_edge(b[i]);
      if (i == 6) begin
        hif.tx_data  = 8'h5A;
        hif.tx_valid = 1'b1;
      end
      if (i < 6) begin
        checks++;
        if ({hif.tx_ready, cnt_out} !== 2'b11) begin
          errors++;
          $display("FAIL pending bit%0d ready/cnt got %b%b want 11", i, hif.tx_ready, cnt_out);
        end
      end
    end
    checks++;
    if ({hif.rx_valid, hif.rx_data} !== {1'b1, 8'hC3}) begin
      errors++;
      $display("FAIL pending rx valid/data got %b/%02h want 1/c3", hif.rx_valid, hif.rx_data);
    end
    tick();
    hif.tx_valid = 1'b0;
    tx_run(8'h5A);
  endtask

  task automatic test_back_to_back();
    send(8'h00, 1'b1, 8'hFF);
    send(8'hFF, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid();
    hif.tx_data  = 8'h00;
    hif.tx_valid = 1'b1;
    tick();
    hif.tx_valid = 1'b0;
    for (int t = 1; t <= 7 * D; t++) tick();
    checks++;
    if ({cnt_out, sp_out, hif.tx_ready} !== 3'b100) begin
      errors++;
      $display("FAIL midbyte before reset cnt/sp/ready got %b%b%b want 100", cnt_out, sp_out, hif.tx_ready);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cnt_out, sp_out, hif.tx_ready, busy, hif.rx_data} !== {4'b1110, 8'h00}) begin
      errors++;
      $display("FAIL midbyte reset cnt/sp/ready/busy/rxd got %b%b%b%b/%02h want 1110/00",
               cnt_out, sp_out, hif.tx_ready, busy, hif.rx_data);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    send(8'h81, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_rx_3c();
    test_timeout();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
